// File: rtl/blake_nonce_scan.sv
// Nonce-sweep controller around the single-block BLAKE-512 core: one hash per nonce, stop at the
// first digest prefix <= target or at the end nonce. Optional watchdog macro: BLAKE_SCAN_WDOG_EN.
module blake_nonce_scan #(
    parameter int NONCE_W = 32,
    parameter int CMP_W   = 64
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               start,
    input  logic               abort,
    input  logic [639:0]       hdr_tmpl,
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [NONCE_W-1:0] nonce_end,
    input  logic [CMP_W-1:0]   target,
    output logic               core_ena,
    output logic [639:0]       core_din,
    input  logic               core_rdy,
    input  logic [511:0]       core_dout,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [NONCE_W-1:0] found_nonce,
    output logic [511:0]       found_hash,
    output logic               err
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, FIN} state_t;
    state_t state, state_nx;

    logic [639:NONCE_W] tmpl_q;
    logic [NONCE_W-1:0] end_q;
    logic [NONCE_W-1:0] nc;
    logic [CMP_W-1:0]   tgt_q;
    logic               abt;
    logic               fresh;
    logic               hit;
    logic               last;
    logic               skip_issue;
    logic               wdog_fire;

    // The template's nonce field is always overwritten, so those input bits are never stored.
    logic unused_tmpl_lo;
    assign unused_tmpl_lo = ^hdr_tmpl[NONCE_W-1:0];

    assign busy       = (state != IDLE);
    assign hit        = (found_hash[511 -: CMP_W] <= tgt_q);
    assign last       = (nc == end_q) || abt;
    // An abort that arrives together with start must still let the first hash go out.
    assign skip_issue = abt && !fresh;

`ifdef BLAKE_SCAN_WDOG_EN
    logic [7:0] wd_cnt;
    assign wdog_fire = (wd_cnt == 8'hFF);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (state == ISSUE)
                wd_cnt <= '0;
            else if (state == WAIT && !core_rdy)
                wd_cnt <= wd_cnt + 8'd1;
            if (state == IDLE && start)
                err <= 1'b0;
            else if (state == WAIT && !core_rdy && wdog_fire)
                err <= 1'b1;
        end
    end
`else
    assign wdog_fire = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ISSUE;
            ISSUE:   state_nx = skip_issue ? FIN : WAIT;
            WAIT: begin
                if (core_rdy)
                    state_nx = CHECK;
                else if (wdog_fire)
                    state_nx = FIN;
            end
            CHECK:   state_nx = (hit || last) ? FIN : ISSUE;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            tmpl_q <= hdr_tmpl[639:NONCE_W];
            end_q  <= nonce_end;
            tgt_q  <= target;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            core_ena    <= 1'b0;
            core_din    <= '0;
            done        <= 1'b0;
            found       <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
            nc          <= '0;
            abt         <= 1'b0;
            fresh       <= 1'b0;
        end else begin
            core_ena <= 1'b0;
            done     <= 1'b0;
            if (state != IDLE && abort)
                abt <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        nc    <= nonce_start;
                        found <= 1'b0;
                        abt   <= abort;
                        fresh <= 1'b1;
                    end
                end
                ISSUE: begin
                    fresh <= 1'b0;
                    if (!skip_issue) begin
                        core_ena <= 1'b1;
                        core_din <= {tmpl_q, nc};
                    end
                end
                WAIT: begin
                    if (core_rdy) begin
                        found_hash  <= core_dout;
                        found_nonce <= nc;
                    end else if (wdog_fire) begin
                        found <= 1'b0;
                    end
                end
                CHECK: begin
                    if (hit)
                        found <= 1'b1;
                    else if (!last)
                        nc <= nc + 1'b1;
                end
                FIN:     done <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_blake_nonce_scan.sv
// Directed bench for blake_nonce_scan: latency-20 core model, cycle-level scan model and scoreboard.
`timescale 1ns/1ps
module tb_blake_nonce_scan;
    logic         clk = 1'b0;
    logic         rstb;
    logic         start;
    logic         abort;
    logic [639:0] hdr_tmpl;
    logic [31:0]  nonce_start;
    logic [31:0]  nonce_end;
    logic [63:0]  target;
    logic         core_ena;
    logic [639:0] core_din;
    logic         core_rdy = 1'b0;
    logic [511:0] core_dout = '0;
    logic         busy;
    logic         done;
    logic         found;
    logic [31:0]  found_nonce;
    logic [511:0] found_hash;
    logic         err;

    always #5 clk = ~clk;

    blake_nonce_scan dut (
        .clk(clk), .rstb(rstb), .start(start), .abort(abort), .hdr_tmpl(hdr_tmpl),
        .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
        .core_ena(core_ena), .core_din(core_din), .core_rdy(core_rdy), .core_dout(core_dout),
        .busy(busy), .done(done), .found(found), .found_nonce(found_nonce),
        .found_hash(found_hash), .err(err)
    );

    // Digest shape: chosen prefix for the configured hit nonce, otherwise a large prefix.
    logic        hit_en = 1'b0;
    logic [31:0] hit_nonce = '0;
    logic [63:0] hit_pfx = '0;
    logic        core_mute = 1'b0;

    function automatic logic [63:0] pfx(input logic [31:0] n);
        if (hit_en && n == hit_nonce) return hit_pfx;
        return {32'hFFFF_0000, n};
    endfunction

    function automatic logic [511:0] dig(input logic [31:0] n);
        return {pfx(n), {14{n ^ 32'h5A5A_5A5A}}};
    endfunction

    int           lat = 0;
    logic [639:0] din_l = '0;
    always @(posedge clk) begin
        #2;
        core_rdy = 1'b0;
        if (lat > 0) begin
            lat = lat - 1;
            if (lat == 0 && !core_mute) begin
                core_rdy  = 1'b1;
                core_dout = dig(din_l[31:0]);
            end
        end
        if (core_ena) begin
            lat   = 20;
            din_l = core_din;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Hand-computed expectations for each scan's final report.
    int          lit_enas = 0;
    logic        lit_found = 1'b0;
    logic [31:0] lit_nonce = '0;
    logic [63:0] lit_pfx = '0;
    logic        lit_err = 1'b0;
    int          tmo_cnt = 0;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [639:0] got, input logic [639:0] want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    logic         act_m = 1'b0, waiting_m = 1'b0, abt_m = 1'b0, hit_m = 1'b0;
    logic         e_ena, e_done;
    int           t_start = 0, exp_ena = -1, exp_done = -1, chk_at = -1, issue_at = -1;
    int           ena_cyc = 0, ena_cnt = 0, tmo_ack = 0;
    logic [639:0] tmpl_m = '0;
    logic [31:0]  nc_m = '0, end_m = '0, exp_fn = '0;
    logic [63:0]  tgt_m = '0;
    logic [511:0] exp_fh = '0;
    logic         exp_found = 1'b0, exp_err = 1'b0;

    always @(negedge clk) begin
        if (tmo_cnt != tmo_ack) begin
            tmo_ack = tmo_cnt;
            total = total + 1;
            bad = bad + 1;
            $display("FAIL wait_bound: got no event within budget, want event (cycle %0d)", cyc);
        end
        if (!rstb) begin
            chk("reset_ctrl", 640'({core_ena, done, busy, found, err}), 640'(0));
            chk("reset_found_nonce", 640'(found_nonce), 640'(0));
            chk("reset_found_hash", 640'(found_hash), 640'(0));
            chk("reset_core_din", core_din, 640'(0));
            act_m = 1'b0; waiting_m = 1'b0; abt_m = 1'b0;
            exp_ena = -1; exp_done = -1; chk_at = -1; issue_at = -1;
            exp_found = 1'b0; exp_fn = '0; exp_fh = '0; exp_err = 1'b0;
        end else begin
            e_done = (cyc == exp_done);
            if (e_done) act_m = 1'b0;
            e_ena = (cyc == exp_ena);
            chk("core_ena", 640'(core_ena), 640'(e_ena));
            if (e_ena) begin
                chk("core_din", core_din, {tmpl_m[639:32], nc_m});
                ena_cnt = ena_cnt + 1;
                waiting_m = 1'b1;
                ena_cyc = cyc;
                exp_ena = -1;
            end
            chk("done", 640'(done), 640'(e_done));
            if (e_done) begin
                chk("lit_hash_count", 640'(ena_cnt), 640'(lit_enas));
                chk("lit_found", 640'(found), 640'(lit_found));
                chk("lit_found_nonce", 640'(found_nonce), 640'(lit_nonce));
                chk("lit_prefix", 640'(found_hash[511:448]), 640'(lit_pfx));
                chk("lit_err", 640'(err), 640'(lit_err));
                exp_done = -1;
            end
            chk("busy", 640'(busy), 640'(act_m && cyc > t_start));
            chk("found", 640'(found), 640'(exp_found));
            chk("found_nonce", 640'(found_nonce), 640'(exp_fn));
            chk("found_hash", 640'(found_hash), 640'(exp_fh));
            chk("err", 640'(err), 640'(exp_err));

            if (cyc == issue_at) begin
                issue_at = -1;
                if (abt_m) exp_done = cyc + 2;
                else exp_ena = cyc + 1;
            end
            if (cyc == chk_at) begin
                chk_at = -1;
                if (hit_m) begin
                    exp_found = 1'b1;
                    exp_done = cyc + 2;
                end else if (nc_m == end_m || abt_m) begin
                    exp_done = cyc + 2;
                end else begin
                    nc_m = nc_m + 32'd1;
                    issue_at = cyc + 1;
                end
            end
            if (act_m && abort) abt_m = 1'b1;
            if (waiting_m && core_rdy) begin
                waiting_m = 1'b0;
                exp_fn = nc_m;
                exp_fh = dig(nc_m);
                hit_m = (pfx(nc_m) <= tgt_m);
                chk_at = cyc + 1;
            end
`ifdef BLAKE_SCAN_WDOG_EN
            else if (waiting_m && cyc == ena_cyc + 255) begin
                waiting_m = 1'b0;
                exp_err = 1'b1;
                exp_found = 1'b0;
                exp_done = cyc + 2;
            end
`endif
            if (start && !act_m) begin
                act_m = 1'b1;
                t_start = cyc;
                tmpl_m = hdr_tmpl;
                nc_m = nonce_start;
                end_m = nonce_end;
                tgt_m = target;
                abt_m = abort;
                exp_ena = cyc + 2;
                exp_found = 1'b0;
                exp_err = 1'b0;
                ena_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_scan(input logic [31:0] s, input logic [31:0] e, input logic [63:0] t,
                           input logic ab);
        tick();
        for (int i = 0; i < 20; i++)
            hdr_tmpl[32*i +: 32] = 32'h1357_0000 + 32'(i) * 32'h0001_0203 + s;
        nonce_start = s;
        nonce_end = e;
        target = t;
        start = 1'b1;
        abort = ab;
        tick();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) tmo_cnt = tmo_cnt + 1;
        repeat (2) tick();
    endtask

    task automatic wait_ena(input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < 200 && seen < n; i++) begin
            @(negedge clk);
            if (core_ena) seen = seen + 1;
        end
        if (seen < n) tmo_cnt = tmo_cnt + 1;
    endtask

    task automatic set_lit(input int n, input logic f, input logic [31:0] nn, input logic [63:0] p,
                           input logic e);
        lit_enas = n; lit_found = f; lit_nonce = nn; lit_pfx = p; lit_err = e;
    endtask

    initial begin
        rstb = 1'b0; start = 1'b0; abort = 1'b0; hdr_tmpl = '0;
        nonce_start = '0; nonce_end = '0; target = '0;
        repeat (3) tick();
        rstb = 1'b1;
        repeat (2) tick();

        // Plain sweep 5..9, nothing hits; a start while busy must be ignored.
        set_lit(5, 1'b0, 32'd9, 64'hFFFF_0000_0000_0009, 1'b0);
        do_scan(32'd5, 32'd9, 64'h0, 1'b0);
        wait_ena(1);
        tick();
        nonce_start = 32'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(300);

        // Equal prefix at nonce 7 is a hit.
        hit_en = 1'b1; hit_nonce = 32'd7; hit_pfx = 64'h10;
        set_lit(3, 1'b1, 32'd7, 64'h10, 1'b0);
        do_scan(32'd5, 32'd9, 64'h10, 1'b0);
        wait_done(300);

        // One above the target is not a hit.
        hit_pfx = 64'h11;
        set_lit(5, 1'b0, 32'd9, 64'hFFFF_0000_0000_0009, 1'b0);
        do_scan(32'd5, 32'd9, 64'h10, 1'b0);
        wait_done(300);

        // Wrap through 0xFFFFFFFF.
        hit_en = 1'b0;
        set_lit(4, 1'b0, 32'd1, 64'hFFFF_0000_0000_0001, 1'b0);
        do_scan(32'hFFFF_FFFE, 32'd1, 64'h0, 1'b0);
        wait_done(300);

        // Abort during the second WAIT, no hit then with a hit.
        set_lit(2, 1'b0, 32'd21, 64'hFFFF_0000_0000_0015, 1'b0);
        do_scan(32'd20, 32'd30, 64'h0, 1'b0);
        wait_ena(2);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(300);

        hit_en = 1'b1; hit_nonce = 32'd21; hit_pfx = 64'h5;
        set_lit(2, 1'b1, 32'd21, 64'h5, 1'b0);
        do_scan(32'd20, 32'd30, 64'h10, 1'b0);
        wait_ena(2);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(300);

        // start == end gives one hash; start together with abort also gives one hash.
        hit_en = 1'b0;
        set_lit(1, 1'b0, 32'd40, 64'hFFFF_0000_0000_0028, 1'b0);
        do_scan(32'd40, 32'd40, 64'h0, 1'b0);
        wait_done(300);
        set_lit(1, 1'b0, 32'd50, 64'hFFFF_0000_0000_0032, 1'b0);
        do_scan(32'd50, 32'd60, 64'h0, 1'b1);
        wait_done(300);

        // Reset during WAIT; the core's late rdy lands in IDLE.
        do_scan(32'd70, 32'd80, 64'h0, 1'b0);
        wait_ena(1);
        repeat (5) tick();
        rstb = 1'b0;
        repeat (2) tick();
        rstb = 1'b1;
        repeat (30) tick();

        set_lit(2, 1'b0, 32'd91, 64'hFFFF_0000_0000_005B, 1'b0);
        do_scan(32'd90, 32'd91, 64'h0, 1'b0);
        wait_done(300);

`ifdef BLAKE_SCAN_WDOG_EN
        core_mute = 1'b1;
        set_lit(1, 1'b0, 32'd91, 64'hFFFF_0000_0000_005B, 1'b1);
        do_scan(32'd100, 32'd105, 64'h0, 1'b0);
        wait_done(400);
        core_mute = 1'b0;
`endif

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
